// File: rtl/divide_pkg.sv
// Shared types and saturation helpers for the pipelined fixed-point divider.
package divide_pkg;

  // Per-slot control carried alongside the data fields of each stage record.
  typedef struct packed {
    logic valid;
    logic neg_dividend;
    logic neg_quotient;
  } div_ctrl_t;

  localparam div_ctrl_t CtrlIdle = '{valid: 1'b0, neg_dividend: 1'b0, neg_quotient: 1'b0};

  // Largest positive two's complement value of the given width, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative value of the given width (equals its magnitude).
  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fixed_point_divide_if.sv
// Operand/result bundle of the fixed-point divider.
interface fixed_point_divide_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] dividend;
  logic signed [DATA_WIDTH-1:0] divisor;
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] quotient;
  logic signed [DATA_WIDTH-1:0] remainder;
  logic                         valid_out;

  modport master (
    output dividend, divisor, valid_in,
    input  quotient, remainder, valid_out
  );

  modport slave (
    input  dividend, divisor, valid_in,
    output quotient, remainder, valid_out
  );
endinterface

// File: rtl/divide_stage.sv
// One registered restoring-division iteration: retires one quotient bit, MSB first.
module divide_stage
  import divide_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BITS   = 42
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] src_rem,
  input  logic [NUM_BITS-1:0]   src_shift,
  input  logic [DATA_WIDTH-1:0] src_dvsr,
  input  div_ctrl_t             src_ctrl,
  output logic [DATA_WIDTH-1:0] dst_rem,
  output logic [NUM_BITS-1:0]   dst_shift,
  output logic [DATA_WIDTH-1:0] dst_dvsr,
  output div_ctrl_t             dst_ctrl
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;
  logic                  carry;
  logic                  qbit;

  // The partial remainder is below the divisor, so a set top bit of the shifted value
  // already guarantees the subtraction succeeds and the low bits wrap to the right result.
  always_comb begin
    shifted      = {src_rem, src_shift[NUM_BITS-1]};
    {carry, diff} = {1'b0, shifted[DATA_WIDTH-1:0]} + {1'b0, ~src_dvsr}
                    + (DATA_WIDTH + 1)'(1);
    qbit         = shifted[DATA_WIDTH] | carry;
  end

  // The shift register drains dividend bits from the top and fills quotient bits below.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dst_rem   <= '0;
      dst_shift <= '0;
      dst_dvsr  <= '0;
      dst_ctrl  <= CtrlIdle;
    end else begin
      dst_rem   <= qbit ? diff : shifted[DATA_WIDTH-1:0];
      dst_shift <= {src_shift[NUM_BITS-2:0], qbit};
      dst_dvsr  <= src_dvsr;
      dst_ctrl  <= src_ctrl;
    end
  end

endmodule

// File: rtl/fixed_point_divide.sv
// Fully pipelined signed fixed-point divider: magnitude/sign input stage, one restoring
// stage per quotient bit, then sign correction and saturation in the output register.
module fixed_point_divide
  import divide_pkg::*;
#(
  parameter int unsigned QUANTIZED_BITS = 10,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input logic                  clock,
  input logic                  reset,
  fixed_point_divide_if.slave  bus
);

  localparam int unsigned NumBits = DATA_WIDTH + QUANTIZED_BITS;

  localparam logic [63:0]           SatMaxWide = sat_max(DATA_WIDTH);
  localparam logic [63:0]           SatMinWide = sat_min(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SatMax     = SatMaxWide[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] SatMin     = SatMinWide[DATA_WIDTH-1:0];
  localparam logic [NumBits-1:0]    PosLimit   = NumBits'(SatMaxWide);
  localparam logic [NumBits-1:0]    NegLimit   = NumBits'(SatMinWide);

  logic [DATA_WIDTH-1:0] rem_s   [NumBits+1];
  logic [NumBits-1:0]    shift_s [NumBits+1];
  logic [DATA_WIDTH-1:0] dvsr_s  [NumBits+1];
  div_ctrl_t             ctrl_s  [NumBits+1];

  logic [DATA_WIDTH-1:0] mag_dividend;
  logic [DATA_WIDTH-1:0] mag_divisor;
  logic [NumBits-1:0]    shift0_q;
  logic [DATA_WIDTH-1:0] dvsr0_q;
  div_ctrl_t             ctrl0_q;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(DATA_WIDTH-1).
  always_comb begin
    mag_dividend = bus.dividend[DATA_WIDTH-1] ? -bus.dividend : bus.dividend;
    mag_divisor  = bus.divisor[DATA_WIDTH-1]  ? -bus.divisor  : bus.divisor;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift0_q <= '0;
      dvsr0_q  <= '0;
      ctrl0_q  <= CtrlIdle;
    end else begin
      shift0_q             <= NumBits'(mag_dividend) << QUANTIZED_BITS;
      dvsr0_q              <= mag_divisor;
      ctrl0_q.valid        <= bus.valid_in;
      ctrl0_q.neg_dividend <= bus.dividend[DATA_WIDTH-1];
      ctrl0_q.neg_quotient <= bus.dividend[DATA_WIDTH-1] ^ bus.divisor[DATA_WIDTH-1];
    end
  end

  assign rem_s[0]   = '0;
  assign shift_s[0] = shift0_q;
  assign dvsr_s[0]  = dvsr0_q;
  assign ctrl_s[0]  = ctrl0_q;

  for (genvar k = 0; k < NumBits; k++) begin : g_stage
    divide_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_BITS   (NumBits)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .src_rem   (rem_s[k]),
      .src_shift (shift_s[k]),
      .src_dvsr  (dvsr_s[k]),
      .src_ctrl  (ctrl_s[k]),
      .dst_rem   (rem_s[k+1]),
      .dst_shift (shift_s[k+1]),
      .dst_dvsr  (dvsr_s[k+1]),
      .dst_ctrl  (ctrl_s[k+1])
    );
  end

  logic [NumBits-1:0]    quot_mag;
  logic [DATA_WIDTH-1:0] rem_mag;
  div_ctrl_t             ctrl_last;
  logic                  div_zero;
  logic [DATA_WIDTH-1:0] quot_d;
  logic [DATA_WIDTH-1:0] rem_d;

  // A zero divisor magnitude at the end of the chain marks a divide-by-zero slot.
  always_comb begin
    quot_mag  = shift_s[NumBits];
    rem_mag   = rem_s[NumBits];
    ctrl_last = ctrl_s[NumBits];
    div_zero  = (dvsr_s[NumBits] == '0);
    quot_d    = '0;
    rem_d     = '0;
    if (ctrl_last.valid) begin
      if (div_zero) begin
        quot_d = ctrl_last.neg_dividend ? SatMin : SatMax;
      end else if (!ctrl_last.neg_quotient && (quot_mag > PosLimit)) begin
        quot_d = SatMax;
      end else if (ctrl_last.neg_quotient && (quot_mag > NegLimit)) begin
        quot_d = SatMin;
      end else begin
        quot_d = ctrl_last.neg_quotient ? -quot_mag[DATA_WIDTH-1:0]
                                        : quot_mag[DATA_WIDTH-1:0];
        rem_d  = ctrl_last.neg_dividend ? -rem_mag : rem_mag;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.quotient  <= quot_d;
      bus.remainder <= rem_d;
      bus.valid_out <= ctrl_last.valid;
    end
  end

endmodule

// File: tb/tb_fixed_point_divide.sv
// Bench for fixed_point_divide: literal directed vectors plus a per-cycle model compare.
module tb_fixed_point_divide;

  localparam int     QB   = 10;
  localparam int     DW   = 32;
  localparam int     LAT  = DW + QB + 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fixed_point_divide_if #(.DATA_WIDTH(DW)) bus ();

  fixed_point_divide #(
    .QUANTIZED_BITS (QB),
    .DATA_WIDTH     (DW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic   v;
    longint q;
    longint r;
  } exp_t;

  exp_t pipe [LAT];

  task automatic check(input string name, input longint got, input longint want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Exact 64-bit arithmetic: truncating division, remainder by definition, then saturate.
  function automatic exp_t model(input logic v, input longint dd, input longint dv);
    exp_t   e;
    longint num;
    longint q;
    e.v = v;
    e.q = 0;
    e.r = 0;
    if (!v) return e;
    if (dv == 0) begin
      e.q = (dd < 0) ? SMIN : SMAX;
      return e;
    end
    num = dd * (longint'(1) << QB);
    q   = num / dv;
    if (q > SMAX) e.q = SMAX;
    else if (q < SMIN) e.q = SMIN;
    else begin
      e.q = q;
      e.r = num - q * dv;
    end
    return e;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '{v: 1'b0, q: 0, r: 0};
    end else begin
      pipe[0] <= model(bus.valid_in, longint'(bus.dividend), longint'(bus.divisor));
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always @(negedge clock) begin
    check("cmp valid_out", longint'(bus.valid_out), longint'(pipe[LAT-1].v));
    check("cmp quotient", longint'(bus.quotient), pipe[LAT-1].q);
    check("cmp remainder", longint'(bus.remainder), pipe[LAT-1].r);
  end

  task automatic run_vec(input string name, input logic signed [31:0] a,
                         input logic signed [31:0] b, input longint eq, input longint er);
    int cyc;
    bit seen;
    bus.dividend = a;
    bus.divisor  = b;
    bus.valid_in = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
      bus.valid_in = 1'b0;
      if (bus.valid_out) seen = 1'b1;
    end
    check({name, " latency"}, longint'(cyc), longint'(LAT));
    check({name, " quotient"}, longint'(bus.quotient), eq);
    check({name, " remainder"}, longint'(bus.remainder), er);
  endtask

  function automatic logic [31:0] rand_op();
    logic signed [31:0] x;
    if ($urandom_range(0, 15) == 0) return '0;
    x = $urandom;
    return x >>> $urandom_range(0, 31);
  endfunction

  initial begin
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.valid_in = 1'b0;
    #1 reset = 1'b0;
    #3;
    check("reset valid_out", longint'(bus.valid_out), 0);
    check("reset quotient", longint'(bus.quotient), 0);
    check("reset remainder", longint'(bus.remainder), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    run_vec("194/10", 32'sd194, 32'sd10, 19865, 6);
    run_vec("-194/10", -32'sd194, 32'sd10, -19865, -6);
    run_vec("194/-10", 32'sd194, -32'sd10, -19865, 6);
    run_vec("1024/512", 32'sd1024, 32'sd512, 2048, 0);
    run_vec("max/1", 32'sh7FFFFFFF, 32'sd1, SMAX, 0);
    run_vec("-5/0", -32'sd5, 32'sd0, SMIN, 0);
    run_vec("0/7", 32'sd0, 32'sd7, 0, 0);
    run_vec("-256/-1024", -32'sd256, -32'sd1024, 256, 0);

    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.valid_in = 1'b0;
        @(posedge clock);
        #1;
      end
      bus.dividend = rand_op();
      bus.divisor  = rand_op();
      bus.valid_in = 1'b1;
      @(posedge clock);
      #1;
      if (i == 30) begin
        #2 reset = 1'b0;
        #1;
        check("midreset valid_out", longint'(bus.valid_out), 0);
        check("midreset quotient", longint'(bus.quotient), 0);
        @(posedge clock);
        #1 reset = 1'b1;
      end
    end
    bus.valid_in = 1'b0;
    repeat (LAT + 4) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
